// File: rtl/face_mask_pkg.sv
// Shared constants and types for the face region masker video stage.
package face_mask_pkg;

  localparam int FRAME_W_DEF = 320;
  localparam int FRAME_H_DEF = 240;
  localparam int DATA_W_DEF  = 16;
  localparam int CRD_W_DEF   = 9;

  localparam logic [2:0] ADDR_X0     = 3'd0;
  localparam logic [2:0] ADDR_Y0     = 3'd1;
  localparam logic [2:0] ADDR_X1     = 3'd2;
  localparam logic [2:0] ADDR_Y1     = 3'd3;
  localparam logic [2:0] ADDR_FILL   = 3'd4;
  localparam logic [2:0] ADDR_CTRL   = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;

  typedef enum logic {
    WAIT_SOP = 1'b0,
    ACTIVE   = 1'b1
  } state_t;

endpackage

// File: rtl/mask_regs.sv
// Avalon-MM register slave: pending region/mode copies, key synchronisers and
// the active shadow set that is reloaded on each accepted start-of-frame beat.
module mask_regs
  import face_mask_pkg::*;
#(
  parameter int CRD_W  = CRD_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  input  logic [1:0]        key_n,
  input  logic              load,
  input  logic [15:0]       frame_cnt,
  input  logic              frame_active,
  input  logic              frame_err,
  output logic [CRD_W-1:0]  x0,
  output logic [CRD_W-1:0]  y0,
  output logic [CRD_W-1:0]  x1,
  output logic [CRD_W-1:0]  y1,
  output logic [DATA_W-1:0] fill,
  output logic              en,
  output logic              mode,
  output logic              bypass
);

  logic [CRD_W-1:0]  p_x0, p_y0, p_x1, p_y1;
  logic [CRD_W-1:0]  a_x0, a_y0, a_x1, a_y1;
  logic [DATA_W-1:0] p_fill, a_fill;
  logic [1:0]        p_ctrl, a_ctrl;
  logic [1:0]        key_s1, key_s2;
  logic              use_pending;
  logic [31:0]       rd_mux;

  wire unused_wdata = ^avs_writedata[31:DATA_W];

  // Region frozen while the hold key is down; otherwise a start-of-frame
  // beat sees the pending set immediately (the load lands one edge later).
  assign use_pending = load && key_s2[1];
  assign bypass      = !key_s2[0];

  assign x0   = use_pending ? p_x0   : a_x0;
  assign y0   = use_pending ? p_y0   : a_y0;
  assign x1   = use_pending ? p_x1   : a_x1;
  assign y1   = use_pending ? p_y1   : a_y1;
  assign fill = use_pending ? p_fill : a_fill;
  assign en   = use_pending ? p_ctrl[CTRL_EN]   : a_ctrl[CTRL_EN];
  assign mode = use_pending ? p_ctrl[CTRL_MODE] : a_ctrl[CTRL_MODE];

  // Pending registers written by the host.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_x0   <= '0;
      p_y0   <= '0;
      p_x1   <= '0;
      p_y1   <= '0;
      p_fill <= '0;
      p_ctrl <= '0;
    end else if (avs_write) begin
      case (avs_address)
        ADDR_X0:   p_x0   <= avs_writedata[CRD_W-1:0];
        ADDR_Y0:   p_y0   <= avs_writedata[CRD_W-1:0];
        ADDR_X1:   p_x1   <= avs_writedata[CRD_W-1:0];
        ADDR_Y1:   p_y1   <= avs_writedata[CRD_W-1:0];
        ADDR_FILL: p_fill <= avs_writedata[DATA_W-1:0];
        ADDR_CTRL: p_ctrl <= avs_writedata[1:0];
        default:   ;
      endcase
    end
  end

  // Active shadow copy; a same-cycle host write is not yet visible here.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_x0   <= '0;
      a_y0   <= '0;
      a_x1   <= '0;
      a_y1   <= '0;
      a_fill <= '0;
      a_ctrl <= '0;
    end else if (use_pending) begin
      a_x0   <= p_x0;
      a_y0   <= p_y0;
      a_x1   <= p_x1;
      a_y1   <= p_y1;
      a_fill <= p_fill;
      a_ctrl <= p_ctrl;
    end
  end

  // Two-flop synchroniser for the asynchronous pushbuttons (idle high).
  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1 <= 2'b11;
      key_s2 <= 2'b11;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
    end
  end

  // Read mux over the pending copies and live status.
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_X0:     rd_mux = 32'(p_x0);
      ADDR_Y0:     rd_mux = 32'(p_y0);
      ADDR_X1:     rd_mux = 32'(p_x1);
      ADDR_Y1:     rd_mux = 32'(p_y1);
      ADDR_FILL:   rd_mux = 32'(p_fill);
      ADDR_CTRL:   rd_mux = 32'(p_ctrl);
      ADDR_STATUS: rd_mux = {14'd0, frame_err, frame_active, frame_cnt};
      default:     rd_mux = '0;
    endcase
  end

  // Registered read data, one cycle latency.
  always_ff @(posedge clk) begin
    if (reset) avs_readdata <= '0;
    else if (avs_read) avs_readdata <= rd_mux;
  end

endmodule

// File: rtl/face_region_masker.sv
// Avalon-ST stage that overwrites a host-programmed rectangle of each frame
// with a solid fill or the inverted pixel; everything else passes through.
//
//  state    | meaning
//  WAIT_SOP | between frames; beats pass unmasked until a start-of-packet
//  ACTIVE   | inside a frame; x/y track the position of the next beat
module face_region_masker
  import face_mask_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int FRAME_H = FRAME_H_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CRD_W   = CRD_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [2:0]        avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  input  logic [1:0]        key_n
);

  localparam int XW = $clog2(FRAME_W);
  localparam int YW = $clog2(FRAME_H + 1);

  state_t            state, state_nx;
  logic [XW-1:0]     x, x_nx, pos_x;
  logic [YW-1:0]     y, y_nx, pos_y;
  logic [15:0]       frame_cnt, frame_cnt_nx;
  logic              err, err_nx;
  logic              accept, in_frame, in_range, last_pix, hit;
  logic [CRD_W-1:0]  rx0, ry0, rx1, ry1;
  logic [DATA_W-1:0] fill, pix;
  logic              en, mode, bypass;

  assign in_ready = out_ready || !out_valid;
  assign accept   = in_valid && in_ready;

  mask_regs #(.CRD_W(CRD_W), .DATA_W(DATA_W)) u_regs (
    .clk           (clk),
    .reset         (reset),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .key_n         (key_n),
    .load          (accept && in_sop),
    .frame_cnt     (frame_cnt),
    .frame_active  (state == ACTIVE),
    .frame_err     (err),
    .x0            (rx0),
    .y0            (ry0),
    .x1            (rx1),
    .y1            (ry1),
    .fill          (fill),
    .en            (en),
    .mode          (mode),
    .bypass        (bypass)
  );

  // Next-state, position tracking, error and frame counting.
  always_comb begin
    state_nx     = state;
    x_nx         = x;
    y_nx         = y;
    err_nx       = err;
    frame_cnt_nx = frame_cnt;
    in_frame     = (state == ACTIVE) || in_sop;
    pos_x        = in_sop ? '0 : x;
    pos_y        = in_sop ? '0 : y;
    in_range     = pos_y < YW'(FRAME_H);
    last_pix     = (pos_x == XW'(FRAME_W - 1)) && (pos_y == YW'(FRAME_H - 1));
    if (accept && in_frame) begin
      state_nx = ACTIVE;
      if (in_sop && state == ACTIVE) err_nx = 1'b1;
      if (!in_range) begin
        err_nx = 1'b1;
        x_nx   = pos_x;
        y_nx   = pos_y;
      end else if (pos_x == XW'(FRAME_W - 1)) begin
        x_nx = '0;
        y_nx = pos_y + YW'(1);
      end else begin
        x_nx = pos_x + XW'(1);
        y_nx = pos_y;
      end
      if (in_eop) begin
        state_nx = WAIT_SOP;
        if (last_pix) begin
          err_nx       = 1'b0;
          frame_cnt_nx = frame_cnt + 16'd1;
        end else begin
          err_nx = 1'b1;
        end
      end
    end
  end

  // Region compare and pixel substitution for the incoming beat.
  always_comb begin
    hit = en && !bypass && in_frame && in_range &&
          (16'(rx0) <= 16'(pos_x)) && (16'(pos_x) <= 16'(rx1)) &&
          (16'(ry0) <= 16'(pos_y)) && (16'(pos_y) <= 16'(ry1));
    pix = in_data;
    if (hit) pix = mode ? ~in_data : fill;
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= WAIT_SOP;
      x         <= '0;
      y         <= '0;
      err       <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_nx;
      x         <= x_nx;
      y         <= y_nx;
      err       <= err_nx;
      frame_cnt <= frame_cnt_nx;
    end
  end

  // Single output stage; holds its beat while the sink stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= pix;
        out_sop  <= in_sop;
        out_eop  <= in_eop;
      end
    end
  end

endmodule

// File: tb/tb_face_region_masker.sv
// Directed bench for face_region_masker on a reduced 16x8 frame.
module tb_face_region_masker;
  import face_mask_pkg::*;

  localparam int W = 16;
  localparam int H = 8;
  localparam int N = W * H;
  localparam int NF = 9;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_sop, in_eop, in_valid, in_ready;
  logic [15:0] out_data;
  logic        out_sop, out_eop, out_valid, out_ready;
  logic [2:0]  avs_address;
  logic        avs_write, avs_read;
  logic [31:0] avs_writedata, avs_readdata;
  logic [1:0]  key_n;

  always #5 clk = ~clk;

  face_region_masker #(.FRAME_W(W), .FRAME_H(H), .DATA_W(16), .CRD_W(9)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_valid(out_valid), .out_ready(out_ready),
    .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_read(avs_read), .avs_readdata(avs_readdata), .key_n(key_n)
  );

  typedef struct packed { logic [15:0] d; logic s; logic e; } beat_t;
  typedef struct { string name; int f; int x; int y; logic [15:0] exp; } spot_t;

  beat_t       cap_q[$];
  logic [15:0] sent [NF][N];
  logic [15:0] got  [NF][N];
  spot_t       spots[14];
  int          checks = 0;
  int          errors = 0;
  bit          bp_en = 1'b0;

  always @(negedge clk)
    if (out_valid && out_ready) cap_q.push_back({out_data, out_sop, out_eop});

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = bp_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mm_write(input logic [2:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    tick();
    avs_write = 1'b0;
  endtask

  task automatic mm_read_chk(input string nm, input logic [2:0] a, input logic [31:0] exp);
    avs_address = a; avs_read = 1'b1;
    tick();
    avs_read = 1'b0;
    checks++;
    if (avs_readdata !== exp) begin
      errors++;
      $display("FAIL %s: readdata=%h expected %h", nm, avs_readdata, exp);
    end
  endtask

  task automatic send_frame(input int f, input int nb, input bit cpat,
                            input int wr_at, input logic [2:0] wa, input logic [31:0] wd);
    int g;
    cap_q.delete();
    for (int i = 0; i < nb; i++) begin
      logic [15:0] d;
      bit acc;
      int guard;
      d = cpat ? 16'h1234 : 16'(f * 256 + i);
      sent[f][i] = d;
      in_data = d; in_sop = (i == 0); in_eop = (i == nb - 1); in_valid = 1'b1;
      if (i == wr_at) begin
        avs_address = wa; avs_writedata = wd; avs_write = 1'b1;
      end
      acc = 1'b0; guard = 0;
      while (!acc && guard < 200) begin
        @(negedge clk); acc = in_ready;
        @(posedge clk); #1;
        guard++;
      end
      avs_write = 1'b0;
      if (!acc) begin
        checks++; errors++;
        $display("FAIL stall_f%0d: beat %0d not accepted within 200 cycles", f, i);
        break;
      end
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    g = 0;
    while (cap_q.size() < nb && g < 300) begin tick(); g++; end
    for (int i = 0; i < nb && i < cap_q.size(); i++) got[f][i] = cap_q[i].d;
  endtask

  task automatic check_frame(input string nm, input int f, input int nb,
                             input int x0, input int x1, input int y0, input int y1,
                             input bit en, input bit inv, input logic [15:0] fill);
    int bad, fi;
    logic [15:0] exp, fexp, fgot;
    bad = 0; fi = -1; fexp = '0; fgot = '0;
    checks++;
    if (cap_q.size() != nb) begin
      errors++;
      $display("FAIL %s: beats=%0d expected %0d", nm, cap_q.size(), nb);
      return;
    end
    for (int i = 0; i < nb; i++) begin
      int x, y;
      x = i % W; y = i / W;
      exp = sent[f][i];
      if (en && i < N && x >= x0 && x <= x1 && y >= y0 && y <= y1)
        exp = inv ? ~sent[f][i] : fill;
      if (cap_q[i].d !== exp || cap_q[i].s !== (i == 0) || cap_q[i].e !== (i == nb - 1)) begin
        if (fi < 0) begin fi = i; fexp = exp; fgot = cap_q[i].d; end
        bad++;
      end
    end
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d bad beats, first idx %0d got %h expected %h", nm, bad, fi, fgot, fexp);
    end
  endtask

  initial begin
    spots[0]  = '{"f0_x9y5",   0,  9, 5, 16'h0059};
    spots[1]  = '{"f0_x10y5",  0, 10, 5, 16'hF800};
    spots[2]  = '{"f0_x12y5",  0, 12, 5, 16'hF800};
    spots[3]  = '{"f0_x13y5",  0, 13, 5, 16'h005D};
    spots[4]  = '{"f0_x11y4",  0, 11, 4, 16'h004B};
    spots[5]  = '{"f0_x11y6",  0, 11, 6, 16'h006B};
    spots[6]  = '{"f1_x11y5",  1, 11, 5, 16'hEDCB};
    spots[7]  = '{"f1_x13y5",  1, 13, 5, 16'h1234};
    spots[8]  = '{"f2_x5y5",   2,  5, 5, 16'h0255};
    spots[9]  = '{"f3_x5y5",   3,  5, 5, 16'hF800};
    spots[10] = '{"f4_x3y5",   4,  3, 5, 16'hF800};
    spots[11] = '{"f5_x3y5",   5,  3, 5, 16'h0553};
    spots[12] = '{"f5_x4y5",   5,  4, 5, 16'hF800};
    spots[13] = '{"f8_x11y5",  8, 11, 5, 16'h085B};

    reset = 1'b1; in_data = '0; in_sop = 1'b0; in_eop = 1'b0; in_valid = 1'b0;
    avs_address = '0; avs_write = 1'b0; avs_writedata = '0; avs_read = 1'b0; key_n = 2'b11;
    tick(); tick();
    reset = 1'b0;
    tick();

    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    checks++;
    if (out_data !== 16'h0 || out_sop !== 1'b0 || out_eop !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: data=%h sop=%b eop=%b expected 0", out_data, out_sop, out_eop);
    end
    mm_read_chk("reset_status", ADDR_STATUS, 32'h0);
    mm_read_chk("reset_ctrl", ADDR_CTRL, 32'h0);
    mm_write(3'd7, 32'hFFFF_FFFF);
    mm_read_chk("addr7", 3'd7, 32'h0);

    mm_write(ADDR_X0, 10); mm_write(ADDR_X1, 12);
    mm_write(ADDR_Y0, 5);  mm_write(ADDR_Y1, 5);
    mm_write(ADDR_FILL, 32'h0000_F800); mm_write(ADDR_CTRL, 1);
    mm_read_chk("rd_fill", ADDR_FILL, 32'h0000_F800);

    send_frame(0, N, 1'b0, -1, 3'd0, 0);
    check_frame("frame0_solid", 0, N, 10, 12, 5, 5, 1, 0, 16'hF800);

    mm_write(ADDR_CTRL, 3);
    send_frame(1, N, 1'b1, -1, 3'd0, 0);
    check_frame("frame1_invert", 1, N, 10, 12, 5, 5, 1, 1, 16'hF800);
    mm_write(ADDR_CTRL, 1);

    send_frame(2, N, 1'b0, 40, ADDR_X0, 2);
    check_frame("frame2_midwrite", 2, N, 10, 12, 5, 5, 1, 0, 16'hF800);

    send_frame(3, N, 1'b0, 0, ADDR_X0, 4);
    check_frame("frame3_newx0", 3, N, 2, 12, 5, 5, 1, 0, 16'hF800);

    key_n = 2'b01;
    repeat (4) tick();
    mm_read_chk("rd_x0_pending", ADDR_X0, 32'd4);
    send_frame(4, N, 1'b0, -1, 3'd0, 0);
    check_frame("frame4_hold", 4, N, 2, 12, 5, 5, 1, 0, 16'hF800);
    key_n = 2'b11;
    repeat (4) tick();

    bp_en = 1'b1;
    send_frame(5, N, 1'b0, -1, 3'd0, 0);
    bp_en = 1'b0;
    tick();
    check_frame("frame5_backpressure", 5, N, 4, 12, 5, 5, 1, 0, 16'hF800);
    mm_read_chk("status_6", ADDR_STATUS, 32'h0000_0006);

    send_frame(6, 100, 1'b0, -1, 3'd0, 0);
    check_frame("frame6_short", 6, 100, 4, 12, 5, 5, 1, 0, 16'hF800);
    mm_read_chk("status_short", ADDR_STATUS, 32'h0002_0006);

    send_frame(7, N, 1'b0, -1, 3'd0, 0);
    check_frame("frame7_recover", 7, N, 4, 12, 5, 5, 1, 0, 16'hF800);
    mm_read_chk("status_recover", ADDR_STATUS, 32'h0000_0007);

    key_n = 2'b10;
    repeat (4) tick();
    send_frame(8, N, 1'b0, -1, 3'd0, 0);
    check_frame("frame8_bypass", 8, N, 4, 12, 5, 5, 0, 0, 16'hF800);
    mm_read_chk("status_bypass", ADDR_STATUS, 32'h0000_0008);
    key_n = 2'b11;

    for (int k = 0; k < 14; k++) begin
      checks++;
      if (got[spots[k].f][spots[k].y * W + spots[k].x] !== spots[k].exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", spots[k].name,
                 got[spots[k].f][spots[k].y * W + spots[k].x], spots[k].exp);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
